// File: rtl/simd_pkg.sv
// rtl/simd_pkg.sv - shared types and instruction field layout for the SIMD fetch path
package simd_pkg;

    localparam int INSTR_WIDTH = 16;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 4;
    localparam int RS2_MSB = 3;
    localparam int RS2_LSB = 0;

    localparam logic [3:0] STOP_OPCODE = 4'h8;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
    } instr_t;

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational split of the instruction register into fields
module instr_decode
    import simd_pkg::*;
(
    input  logic [INSTR_WIDTH-1:0] ir,
    output logic [3:0]             op,
    output logic [3:0]             rd,
    output logic [3:0]             rs1,
    output logic [3:0]             rs2
);

    instr_t fields;

    // Slice the word into named fields; no register, so fields track ir directly.
    always_comb begin
        fields.op  = ir[OP_MSB:OP_LSB];
        fields.rd  = ir[RD_MSB:RD_LSB];
        fields.rs1 = ir[RS1_MSB:RS1_LSB];
        fields.rs2 = ir[RS2_MSB:RS2_LSB];
    end

    assign op  = fields.op;
    assign rd  = fields.rd;
    assign rs1 = fields.rs1;
    assign rs2 = fields.rs2;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: drives imem, returns opcode to the PC, fills the IR
module instr_fetch
    import simd_pkg::*;
#(
    parameter int                    PC_WIDTH    = 12,
    parameter int                    OPCODE_LEN  = 4,
    parameter logic [OPCODE_LEN-1:0] STOP_OPCODE = OPCODE_LEN'(simd_pkg::STOP_OPCODE)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [PC_WIDTH-1:0]    pc_in,
    output logic [PC_WIDTH-1:0]    imem_addr,
    output logic                   imem_en,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [OPCODE_LEN-1:0]  opcode_out,
    output logic [INSTR_WIDTH-1:0] ir,
    output logic                   ir_valid,
    output logic [3:0]             op,
    output logic [3:0]             rd,
    output logic [3:0]             rs1,
    output logic [3:0]             rs2,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [PC_WIDTH:0]      instr_count
);

    localparam int CNT_W = PC_WIDTH + 1;

    fetch_state_t            state_q, state_d;
    logic [INSTR_WIDTH-1:0]  ir_q, ir_d;
    logic                    ir_valid_q, ir_valid_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [OPCODE_LEN-1:0]   fetched_op;
    logic                    is_fetch;
    logic                    is_stop;
    logic                    overflow;

    // The memory read is combinational, so the opcode of the word at pc_in is
    // available in the same cycle and can be fed straight back to the PC.
    assign fetched_op = imem_rdata[OP_MSB -: OPCODE_LEN];
    assign is_fetch   = (state_q == FETCH);
    assign is_stop    = is_fetch && (fetched_op == STOP_OPCODE);
    // Last address reached without a STOP: the PC would wrap, so end the run here.
    assign overflow   = is_fetch && (pc_in == {PC_WIDTH{1'b1}}) && !is_stop;

    // Memory-side and PC-side outputs; a forced STOP on overflow makes the PC reset.
    always_comb begin
        imem_addr  = pc_in;
        imem_en    = is_fetch;
        busy       = is_fetch;
        opcode_out = '0;
        if (is_fetch) begin
            opcode_out = overflow ? STOP_OPCODE : fetched_op;
        end
    end

    // Next-state logic: run control, IR capture, saturating instruction count.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        ir_valid_d = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            FETCH: begin
                if (is_stop) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (overflow) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    ir_d       = imem_rdata;
                    ir_valid_d = 1'b1;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ir          = ir_q;
    assign ir_valid    = ir_valid_q;
    assign done        = done_q;
    assign err         = err_q;
    assign instr_count = cnt_q;

    instr_decode u_decode (
        .ir  (ir_q),
        .op  (op),
        .rd  (rd),
        .rs1 (rs1),
        .rs2 (rs2)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [11:0] pc;
    logic [11:0] imem_addr;
    logic        imem_en;
    logic [15:0] imem_rdata;
    logic [3:0]  opcode_out;
    logic [15:0] ir;
    logic        ir_valid;
    logic [3:0]  op, rd, rs1, rs2;
    logic        busy, done, err;
    logic [12:0] instr_count;

    logic [15:0] mem [0:4095];

    int checks   = 0;
    int failures = 0;

    instr_fetch dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .pc_in       (pc),
        .imem_addr   (imem_addr),
        .imem_en     (imem_en),
        .imem_rdata  (imem_rdata),
        .opcode_out  (opcode_out),
        .ir          (ir),
        .ir_valid    (ir_valid),
        .op          (op),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr];

    // Program counter model: load 0 on start, advance while fetching, reset on STOP.
    always @(posedge clk) begin
        if (!rstn)                            pc <= 12'h000;
        else if (busy && opcode_out == 4'h8)  pc <= 12'h000;
        else if (busy)                        pc <= pc + 12'h001;
        else if (start)                       pc <= 12'h000;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(negedge clk);
    endtask

    task automatic fill_mem(input logic [15:0] w);
        for (int a = 0; a < 4096; a++) mem[a] = w;
    endtask

    task automatic load_prog;
        fill_mem(16'h0000);
        mem[0] = 16'h1123;
        mem[1] = 16'h2456;
        mem[2] = 16'h8000;
    endtask

    task automatic test_reset;
        rstn = 1'b0; start = 1'b0;
        step(); step();
        rstn = 1'b1;
        checks++; if (ir !== 16'h0000) begin failures++; $display("FAIL reset_ir got=%h exp=0000", ir); end
        checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL reset_ir_valid got=%b exp=0", ir_valid); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (instr_count !== 13'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", instr_count); end
        checks++; if (busy !== 1'b0 || imem_en !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b/%b exp=0/0", busy, imem_en); end
        checks++; if (opcode_out !== 4'h0) begin failures++; $display("FAIL reset_opcode got=%h exp=0", opcode_out); end
    endtask

    task automatic test_program;
        load_prog();
        start = 1'b1; step(); start = 1'b0;
        checks++; if (busy !== 1'b1 || imem_en !== 1'b1) begin failures++; $display("FAIL prog_busy got=%b/%b exp=1/1", busy, imem_en); end
        checks++; if (imem_addr !== 12'h000) begin failures++; $display("FAIL prog_addr0 got=%h exp=000", imem_addr); end
        checks++; if (opcode_out !== 4'h1) begin failures++; $display("FAIL prog_opc0 got=%h exp=1", opcode_out); end
        checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL prog_valid0 got=%b exp=0", ir_valid); end
        step();
        checks++; if (ir !== 16'h1123 || ir_valid !== 1'b1) begin failures++; $display("FAIL prog_ir1 got=%h/%b exp=1123/1", ir, ir_valid); end
        checks++; if ({op, rd, rs1, rs2} !== 16'h1123) begin failures++; $display("FAIL prog_fields got=%h %h %h %h exp=1 1 2 3", op, rd, rs1, rs2); end
        checks++; if (instr_count !== 13'd1) begin failures++; $display("FAIL prog_count1 got=%0d exp=1", instr_count); end
        checks++; if (opcode_out !== 4'h2) begin failures++; $display("FAIL prog_opc1 got=%h exp=2", opcode_out); end
        step();
        checks++; if (ir !== 16'h2456 || ir_valid !== 1'b1) begin failures++; $display("FAIL prog_ir2 got=%h/%b exp=2456/1", ir, ir_valid); end
        checks++; if (imem_addr !== 12'h002 || opcode_out !== 4'h8) begin failures++; $display("FAIL prog_stop_opc got=%h/%h exp=002/8", imem_addr, opcode_out); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL prog_done_early got=%b exp=0", done); end
        step();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL prog_done got=%b exp=1", done); end
        checks++; if (ir_valid !== 1'b0 || ir !== 16'h2456) begin failures++; $display("FAIL prog_ir_hold got=%h/%b exp=2456/0", ir, ir_valid); end
        checks++; if (instr_count !== 13'd2) begin failures++; $display("FAIL prog_count2 got=%0d exp=2", instr_count); end
        checks++; if (busy !== 1'b0 || imem_en !== 1'b0 || opcode_out !== 4'h0) begin failures++; $display("FAIL prog_idle got=%b/%b/%h exp=0/0/0", busy, imem_en, opcode_out); end
        step();
        checks++; if (done !== 1'b0 || instr_count !== 13'd2) begin failures++; $display("FAIL prog_after got=%b/%0d exp=0/2", done, instr_count); end
    endtask

    task automatic test_empty;
        fill_mem(16'h0000);
        mem[0] = 16'h8000;
        start = 1'b1; step(); start = 1'b0;
        checks++; if (busy !== 1'b1 || opcode_out !== 4'h8 || ir_valid !== 1'b0) begin failures++; $display("FAIL empty_fetch got=%b/%h/%b exp=1/8/0", busy, opcode_out, ir_valid); end
        step();
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL empty_done got=%b/%b exp=1/0", done, busy); end
        checks++; if (instr_count !== 13'd0 || ir_valid !== 1'b0) begin failures++; $display("FAIL empty_count got=%0d/%b exp=0/0", instr_count, ir_valid); end
        step();
        checks++; if (done !== 1'b0 || busy !== 1'b0 || ir_valid !== 1'b0) begin failures++; $display("FAIL empty_after got=%b/%b/%b exp=0/0/0", done, busy, ir_valid); end
    endtask

    task automatic test_overflow;
        logic       seen_done, saw_fff;
        logic [3:0] opc_fff;
        seen_done = 1'b0; saw_fff = 1'b0; opc_fff = 4'h0;
        fill_mem(16'h1000);
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (pc == 12'hFFF && busy) begin saw_fff = 1'b1; opc_fff = opcode_out; end
            if (done) begin seen_done = 1'b1; break; end
            step();
        end
        checks++; if (seen_done !== 1'b1) begin failures++; $display("FAIL ovf_timeout got=%b exp=1", seen_done); end
        checks++; if (saw_fff !== 1'b1 || opc_fff !== 4'h8) begin failures++; $display("FAIL ovf_opc got=%b/%h exp=1/8", saw_fff, opc_fff); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL ovf_err got=%b exp=1", err); end
        checks++; if (instr_count !== 13'd4095) begin failures++; $display("FAIL ovf_count got=%0d exp=4095", instr_count); end
        checks++; if (pc !== 12'h000 || busy !== 1'b0 || ir_valid !== 1'b0) begin failures++; $display("FAIL ovf_pc got=%h/%b/%b exp=000/0/0", pc, busy, ir_valid); end
        step();
        checks++; if (err !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL ovf_sticky got=%b/%b exp=1/0", err, done); end
    endtask

    task automatic test_back_to_back;
        load_prog();
        start = 1'b1; step(); start = 1'b0;
        checks++; if (err !== 1'b0 || instr_count !== 13'd0) begin failures++; $display("FAIL rerun_clear got=%b/%0d exp=0/0", err, instr_count); end
        step();
        checks++; if (ir !== 16'h1123 || instr_count !== 13'd1) begin failures++; $display("FAIL rerun_ir1 got=%h/%0d exp=1123/1", ir, instr_count); end
        start = 1'b1; step(); start = 1'b0;
        checks++; if (ir !== 16'h2456 || instr_count !== 13'd2 || busy !== 1'b1) begin failures++; $display("FAIL rerun_ignore got=%h/%0d/%b exp=2456/2/1", ir, instr_count, busy); end
        step();
        checks++; if (done !== 1'b1 || instr_count !== 13'd2 || ir !== 16'h2456) begin failures++; $display("FAIL rerun_done got=%b/%0d/%h exp=1/2/2456", done, instr_count, ir); end
        step();
    endtask

    task automatic test_reset_mid;
        fill_mem(16'h1000);
        mem[6] = 16'h8000;
        start = 1'b1; step(); start = 1'b0;
        step(); step(); step();
        checks++; if (pc !== 12'h003 || busy !== 1'b1) begin failures++; $display("FAIL mid_pre got=%h/%b exp=003/1", pc, busy); end
        rstn = 1'b0; step(); rstn = 1'b1;
        checks++; if (busy !== 1'b0 || imem_en !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b/%b exp=0/0", busy, imem_en); end
        checks++; if (ir !== 16'h0000 || ir_valid !== 1'b0) begin failures++; $display("FAIL mid_ir got=%h/%b exp=0000/0", ir, ir_valid); end
        checks++; if (err !== 1'b0 || instr_count !== 13'd0 || done !== 1'b0) begin failures++; $display("FAIL mid_regs got=%b/%0d/%b exp=0/0/0", err, instr_count, done); end
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_stay got=%b exp=0", busy); end
    endtask

    task automatic test_start_with_reset;
        load_prog();
        rstn = 1'b0; start = 1'b1; step();
        rstn = 1'b1; start = 1'b0;
        checks++; if (busy !== 1'b0 || imem_en !== 1'b0 || opcode_out !== 4'h0) begin failures++; $display("FAIL rst_start got=%b/%b/%h exp=0/0/0", busy, imem_en, opcode_out); end
        step();
        checks++; if (busy !== 1'b0 || ir_valid !== 1'b0) begin failures++; $display("FAIL rst_start_idle got=%b/%b exp=0/0", busy, ir_valid); end
    endtask

    initial begin
        rstn  = 1'b0;
        start = 1'b0;
        fill_mem(16'h0000);
        step();
        test_reset();
        test_program();
        test_empty();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_start_with_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
